dfi_mem_model: RTL and testbench

DFI_MEM_MODEL -- requirements
Module: dfi_mem_model

---
 rtl/dfi_mem_model.sv | 198 +++++++++++++++++++
 tb/tb_dfi_mem_model.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfi_mem_model.sv
// DFI-side DDR memory model: command decode, per-bank row table, read/write column queues and a
// fixed-latency read pipe. Define DFI_MEM_MODEL_CHECK_EN to enable bank-state protocol checks.
module dfi_mem_model #(
  parameter int unsigned TPHY_RDLAT  = 5,
  parameter int unsigned INIT_CYCLES = 16,
  parameter int unsigned ROW_BITS    = 2,
  parameter int unsigned QDEPTH      = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        dfi_cs_n_i,
  input  logic        dfi_ras_n_i,
  input  logic        dfi_cas_n_i,
  input  logic        dfi_we_n_i,
  input  logic [2:0]  dfi_bank_i,
  input  logic [14:0] dfi_address_i,
  input  logic        dfi_cke_i,
  input  logic        dfi_odt_i,
  input  logic        dfi_reset_n_i,
  input  logic [31:0] dfi_wrdata_i,
  input  logic [3:0]  dfi_wrdata_mask_i,
  input  logic        dfi_wrdata_en_i,
  input  logic        dfi_rddata_en_i,
  output logic [31:0] dfi_rddata_o,
  output logic        dfi_rddata_valid_o,
  input  logic        dfi_init_start_i,
  output logic        dfi_init_complete_o,
  output logic        err_o
);
  localparam int unsigned EntW  = 3 + ROW_BITS + 7;
  localparam int unsigned IdxW  = EntW + 2;
  localparam int unsigned PtrW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW  = $clog2(QDEPTH + 1);
  localparam int unsigned InitW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;

  localparam logic [3:0] CmdNop    = 4'b0111;
  localparam logic [3:0] CmdActive = 4'b0011;
  localparam logic [3:0] CmdRead   = 4'b0101;
  localparam logic [3:0] CmdWrite  = 4'b0100;
  localparam logic [3:0] CmdPre    = 4'b0010;

  typedef enum logic [1:0] {StIdle, StInit, StReady} state_e;

  state_e              st_q, st_d;
  logic [InitW-1:0]    init_cnt_q, init_cnt_d;
  logic                err_q, err_d;
  logic [7:0]          bank_open_q, bank_open_d;
  logic [ROW_BITS-1:0] bank_row_q [8];

  logic [3:0] cmd;
  logic       cmd_nop, ready, cmd_act, cmd_rd, cmd_wr, cmd_pre;
  logic       proto_err, chk_err;

  logic [EntW-1:0] rq_ent_q [QDEPTH];
  logic [EntW-1:0] wq_ent_q [QDEPTH];
  logic [PtrW-1:0] rq_wptr_q, rq_rptr_q, wq_wptr_q, wq_rptr_q;
  logic [CntW-1:0] rq_cnt_q, wq_cnt_q;
  logic [1:0]      rq_beat_q, wq_beat_q;
  logic            rq_hit, rq_pop, rq_ok, wq_hit, wq_pop, wq_ok;
  logic [EntW-1:0] new_ent;
  logic [IdxW-1:0] ridx, widx;

  logic [31:0]           mem_q [2**IdxW];
  logic [31:0]           rdata;
  logic [TPHY_RDLAT-1:0] pipe_vld_q;
  logic [31:0]           pipe_data_q [TPHY_RDLAT];

  logic unused_inputs;
  assign unused_inputs = ^{dfi_cke_i, dfi_odt_i, dfi_reset_n_i, dfi_address_i};

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(QDEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign cmd     = {dfi_cs_n_i, dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i};
  assign cmd_nop = dfi_cs_n_i | (cmd == CmdNop);
  assign ready   = (st_q == StReady);
  assign cmd_act = ready & ~cmd_nop & (cmd == CmdActive);
  assign cmd_rd  = ready & ~cmd_nop & (cmd == CmdRead);
  assign cmd_wr  = ready & ~cmd_nop & (cmd == CmdWrite);
  assign cmd_pre = ready & ~cmd_nop & (cmd == CmdPre);

  // Row is captured at push time so a later ACTIVE cannot retarget a queued burst.
  assign new_ent = {dfi_bank_i, bank_row_q[dfi_bank_i], dfi_address_i[9:3]};

  assign rq_hit = dfi_rddata_en_i & (rq_cnt_q != '0);
  assign rq_pop = rq_hit & (rq_beat_q == 2'd3);
  assign rq_ok  = cmd_rd & ((rq_cnt_q != CntW'(QDEPTH)) | rq_pop);
  assign wq_hit = dfi_wrdata_en_i & (wq_cnt_q != '0);
  assign wq_pop = wq_hit & (wq_beat_q == 2'd3);
  assign wq_ok  = cmd_wr & ((wq_cnt_q != CntW'(QDEPTH)) | wq_pop);

  assign ridx  = {rq_ent_q[rq_rptr_q], rq_beat_q};
  assign widx  = {wq_ent_q[wq_rptr_q], wq_beat_q};
  assign rdata = rq_hit ? mem_q[ridx] : '0;

  assign proto_err = (~cmd_nop & ~ready) | (cmd_rd & ~rq_ok) | (cmd_wr & ~wq_ok)
                   | (dfi_rddata_en_i & ~rq_hit) | (dfi_wrdata_en_i & ~wq_hit);

`ifdef DFI_MEM_MODEL_CHECK_EN
  localparam logic [3:0] CmdRef = 4'b0001;
  assign chk_err = (cmd_act & bank_open_q[dfi_bank_i])
                 | ((cmd_rd | cmd_wr) & ~bank_open_q[dfi_bank_i])
                 | (ready & ~cmd_nop & (cmd == CmdRef) & (|bank_open_q));
`else
  assign chk_err = 1'b0;
`endif

  assign err_d = err_q | proto_err | chk_err;

  always_comb begin
    st_d       = st_q;
    init_cnt_d = init_cnt_q;
    unique case (st_q)
      StIdle: begin
        if (dfi_init_start_i) begin
          st_d       = StInit;
          init_cnt_d = InitW'(1);
        end
      end
      StInit: begin
        if (init_cnt_q >= InitW'(INIT_CYCLES - 1)) st_d = StReady;
        else init_cnt_d = init_cnt_q + InitW'(1);
      end
      StReady: st_d = StReady;
      default: st_d = StIdle;
    endcase
  end

  always_comb begin
    bank_open_d = bank_open_q;
    if (cmd_act) bank_open_d[dfi_bank_i] = 1'b1;
    if (cmd_pre) begin
      if (dfi_address_i[10]) bank_open_d = '0;
      else bank_open_d[dfi_bank_i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      st_q        <= StIdle;
      init_cnt_q  <= '0;
      err_q       <= 1'b0;
      bank_open_q <= '0;
      rq_wptr_q   <= '0;
      rq_rptr_q   <= '0;
      rq_cnt_q    <= '0;
      rq_beat_q   <= '0;
      wq_wptr_q   <= '0;
      wq_rptr_q   <= '0;
      wq_cnt_q    <= '0;
      wq_beat_q   <= '0;
      pipe_vld_q  <= '0;
      for (int i = 0; i < TPHY_RDLAT; i++) pipe_data_q[i] <= '0;
      for (int i = 0; i < 8; i++) bank_row_q[i] <= '0;
    end else begin
      st_q        <= st_d;
      init_cnt_q  <= init_cnt_d;
      err_q       <= err_d;
      bank_open_q <= bank_open_d;
      if (cmd_act) bank_row_q[dfi_bank_i] <= dfi_address_i[ROW_BITS-1:0];
      if (rq_ok) rq_wptr_q <= ptr_inc(rq_wptr_q);
      if (rq_pop) rq_rptr_q <= ptr_inc(rq_rptr_q);
      rq_cnt_q <= rq_cnt_q + CntW'(rq_ok) - CntW'(rq_pop);
      if (rq_hit) rq_beat_q <= rq_beat_q + 2'd1;
      if (wq_ok) wq_wptr_q <= ptr_inc(wq_wptr_q);
      if (wq_pop) wq_rptr_q <= ptr_inc(wq_rptr_q);
      wq_cnt_q <= wq_cnt_q + CntW'(wq_ok) - CntW'(wq_pop);
      if (wq_hit) wq_beat_q <= wq_beat_q + 2'd1;
      // An enable beat with an empty queue still emits a (zero) valid beat.
      pipe_vld_q[0]  <= dfi_rddata_en_i;
      pipe_data_q[0] <= rdata;
      for (int i = 1; i < TPHY_RDLAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  // Queue payloads and memory are deliberately not reset; contents survive rst_n_i.
  always_ff @(posedge clk_i) begin
    if (rq_ok) rq_ent_q[rq_wptr_q] <= new_ent;
    if (wq_ok) wq_ent_q[wq_wptr_q] <= new_ent;
  end

  always_ff @(posedge clk_i) begin
    if (rst_n_i && wq_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (!dfi_wrdata_mask_i[b]) mem_q[widx][8*b +: 8] <= dfi_wrdata_i[8*b +: 8];
      end
    end
  end

  assign dfi_rddata_o        = pipe_data_q[TPHY_RDLAT-1];
  assign dfi_rddata_valid_o  = pipe_vld_q[TPHY_RDLAT-1];
  assign dfi_init_complete_o = ready;
  assign err_o               = err_q;
endmodule

// File: tb/tb_dfi_mem_model.sv
// Bench for dfi_mem_model: table-driven write/readback vectors plus hand sequences for streaming,
// reset mid-burst, protocol errors and queue overflow; reads are scored against a timed queue.
module tb_dfi_mem_model;
  localparam int unsigned RdLat   = 5;
  localparam int unsigned InitCyc = 16;
  localparam logic [3:0] CNop = 4'b1111;
  localparam logic [3:0] CAct = 4'b0011;
  localparam logic [3:0] CRd  = 4'b0101;
  localparam logic [3:0] CWr  = 4'b0100;
  localparam logic [3:0] CPre = 4'b0010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [2:0]  bank;
  logic [14:0] addr;
  logic        cke, odt, reset_n;
  logic [31:0] wrdata;
  logic [3:0]  wrmask;
  logic        wren, rden;
  logic [31:0] rddata;
  logic        rdvalid;
  logic        init_start, init_cplt, err;

  always #5 clk = ~clk;

  dfi_mem_model #(
    .TPHY_RDLAT (RdLat),
    .INIT_CYCLES(InitCyc),
    .ROW_BITS   (2),
    .QDEPTH     (4)
  ) u_dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .dfi_cs_n_i         (cs_n),
    .dfi_ras_n_i        (ras_n),
    .dfi_cas_n_i        (cas_n),
    .dfi_we_n_i         (we_n),
    .dfi_bank_i         (bank),
    .dfi_address_i      (addr),
    .dfi_cke_i          (cke),
    .dfi_odt_i          (odt),
    .dfi_reset_n_i      (reset_n),
    .dfi_wrdata_i       (wrdata),
    .dfi_wrdata_mask_i  (wrmask),
    .dfi_wrdata_en_i    (wren),
    .dfi_rddata_en_i    (rden),
    .dfi_rddata_o       (rddata),
    .dfi_rddata_valid_o (rdvalid),
    .dfi_init_start_i   (init_start),
    .dfi_init_complete_o(init_cplt),
    .err_o              (err)
  );

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  typedef struct {
    logic [2:0]       bank;
    logic [1:0]       row;
    logic [9:0]       col;
    bit               wr;
    logic [3:0][31:0] wdata;
    logic [3:0]       mask;
    logic [3:0][31:0] exp;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;
  logic [31:0] exp_chk;
  vec_t        vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        check("rd_valid", 32'(rdvalid), 32'd1);
        check("rd_data", rddata, mon_e.data);
      end else if (rdvalid !== 1'b0) begin
        check("spurious_valid", 32'(rdvalid), 32'd0);
      end
    end
  end

  task automatic idle_inputs();
    {cs_n, ras_n, cas_n, we_n} = CNop;
    bank = '0; addr = '0; cke = 1'b1; odt = 1'b0; reset_n = 1'b1;
    wrdata = '0; wrmask = '0; wren = 1'b0; rden = 1'b0; init_start = 1'b0;
  endtask

  task automatic cmd(input logic [3:0] c, input logic [2:0] b, input logic [14:0] a);
    {cs_n, ras_n, cas_n, we_n} = c;
    bank = b;
    addr = a;
    @(posedge clk); #1;
    {cs_n, ras_n, cas_n, we_n} = CNop;
  endtask

  task automatic wr_beats(input logic [3:0][31:0] d, input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      wren = 1'b1; wrdata = d[i]; wrmask = m;
      @(posedge clk); #1;
    end
    wren = 1'b0;
  endtask

  task automatic rd_beats(input int n, input logic [7:0][31:0] e);
    exp_t t;
    for (int i = 0; i < n; i++) begin
      rden = 1'b1;
      t.data = e[i];
      t.due = cyc + RdLat;
      sb.push_back(t);
      @(posedge clk); #1;
    end
    rden = 1'b0;
  endtask

  task automatic drain();
    exp_t t;
    for (int k = 0; k < int'(RdLat) + 8 && sb.size() > 0; k++) @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      t = sb.pop_front();
      check("rd_timeout", 32'd0, t.data ^ 32'hFFFF_FFFF ^ t.data);
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic do_init(input bit exact);
    bit done;
    logic c;
    done = 1'b0;
    init_start = 1'b1;
    for (int k = 0; k <= 100 && !done; k++) begin
      @(negedge clk);
      c = init_cplt;
      if (exact) check($sformatf("init_cplt_c%0d", k), 32'(c), (k >= int'(InitCyc)) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      init_start = 1'b0;
      done = (c === 1'b1) || (exact && k >= int'(InitCyc));
    end
    if (!done) check("init_timeout", 32'(init_cplt), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {bank, row, col, wr, wdata {b3,b2,b1,b0}, mask, expected readback {b3,b2,b1,b0}}
    vecs[0] = '{3'd0, 2'd0, 10'd0, 1'b1,
                {32'h7A7A6969, 32'h79796868, 32'h78786767, 32'h77776666}, 4'h0,
                {32'h7A7A6969, 32'h79796868, 32'h78786767, 32'h77776666}};
    vecs[1] = '{3'd1, 2'd3, 10'h3F8, 1'b1,
                {32'h0BADF00D, 32'h12345678, 32'hCAFEF00D, 32'hDEADBEEF}, 4'h0,
                {32'h0BADF00D, 32'h12345678, 32'hCAFEF00D, 32'hDEADBEEF}};
    vecs[2] = '{3'd0, 2'd0, 10'd0, 1'b1,
                {4{32'hFFFFFFFF}}, 4'h0, {4{32'hFFFFFFFF}}};
    vecs[3] = '{3'd0, 2'd0, 10'd0, 1'b1,
                {4{32'h00000000}}, 4'b0101, {4{32'h00FF00FF}}};
    vecs[4] = '{3'd7, 2'd1, 10'd5, 1'b1,
                {32'hDDEEFF00, 32'h99AABBCC, 32'h55667788, 32'h11223344}, 4'b1110,
                {32'h00000000, 32'h000000CC, 32'h00000088, 32'h00000044}};
    vecs[5] = '{3'd6, 2'd2, 10'h100, 1'b0,
                {4{32'h0}}, 4'h0, {4{32'h0}}};

    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_valid", 32'(rdvalid), 32'd0);
    check("rst_rddata", rddata, 32'd0);
    check("rst_cplt", 32'(init_cplt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    do_init(1'b1);
    check("init_err", 32'(err), 32'd0);

    for (int i = 0; i < 6; i++) begin
      cmd(CPre, 3'd0, 15'h400);
      cmd(CAct, vecs[i].bank, 15'(vecs[i].row));
      if (vecs[i].wr) begin
        cmd(CWr, vecs[i].bank, 15'(vecs[i].col));
        wr_beats(vecs[i].wdata, vecs[i].mask);
      end
      cmd(CRd, vecs[i].bank, 15'(vecs[i].col));
      rd_beats(4, {128'h0, vecs[i].exp});
      drain();
      check($sformatf("vec%0d_err", i), 32'(err), 32'd0);
    end

    // Two back-to-back read bursts streamed with eight contiguous enable beats.
    cmd(CPre, 3'd0, 15'h400);
    cmd(CAct, 3'd2, 15'd0);
    cmd(CWr, 3'd2, 15'd2);
    wr_beats({32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0}, 4'h0);
    cmd(CWr, 3'd2, 15'd999);
    wr_beats({32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0}, 4'h0);
    cmd(CRd, 3'd2, 15'd2);
    cmd(CRd, 3'd2, 15'd999);
    rd_beats(8, {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0,
                 32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0});
    drain();
    check("stream_err", 32'(err), 32'd0);

    // Reset two cycles into a read burst: in-flight beats vanish, memory survives.
    cmd(CPre, 3'd0, 15'h400);
    cmd(CAct, 3'd3, 15'd0);
    cmd(CWr, 3'd3, 15'd8);
    wr_beats({32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0}, 4'h0);
    cmd(CRd, 3'd3, 15'd8);
    rden = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();
    check("rst2_cplt", 32'(init_cplt), 32'd0);
    check("rst2_err", 32'(err), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rst2_no_valid", 32'(rdvalid), 32'd0);
    end
    @(posedge clk); #1;
    do_init(1'b0);
    cmd(CAct, 3'd3, 15'd0);
    cmd(CRd, 3'd3, 15'd8);
    rd_beats(4, {128'h0, 32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0});
    drain();
    check("rst2_readback_err", 32'(err), 32'd0);

    // READ to a closed bank only flags an error when checks are compiled in.
`ifdef DFI_MEM_MODEL_CHECK_EN
    exp_chk = 32'd1;
`else
    exp_chk = 32'd0;
`endif
    cmd(CRd, 3'd5, 15'd0);
    check("closed_rd_err", 32'(err), exp_chk);
    repeat (3) @(posedge clk);
    #1;
    check("closed_rd_err_sticky", 32'(err), exp_chk);

    // Fifth READ into a full queue is dropped and flags an error.
    do_reset();
    do_init(1'b0);
    cmd(CAct, 3'd3, 15'd0);
    for (int i = 0; i < 4; i++) cmd(CRd, 3'd3, 15'd8);
    check("qfull_pre_err", 32'(err), 32'd0);
    cmd(CRd, 3'd3, 15'd8);
    check("qfull_err", 32'(err), 32'd1);

    // Enable beat with an empty queue: zero data, valid still emitted, error set.
    do_reset();
    do_init(1'b0);
    check("empty_pre_err", 32'(err), 32'd0);
    rd_beats(1, {256'h0});
    drain();
    check("empty_en_err", 32'(err), 32'd1);

    // Command before init completes is an error.
    do_reset();
    cmd(CAct, 3'd0, 15'd0);
    check("preinit_err", 32'(err), 32'd1);
    check("preinit_cplt", 32'(init_cplt), 32'd0);

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
